// File: rtl/stg3_accum.sv
// stg3_accum: 4-phase handshake stage that sums 16 buffered 32-bit lanes modulo 2^32.
// Define STG3_DUAL_LANE_EN to add two lanes per edge (latency 8 instead of 16).
module stg3_accum (
  input  logic         clk,
  input  logic         reset,
  input  logic         Rin,
  output logic         Ain,
  input  logic [511:0] data_in,
  output logic         Rout,
  input  logic         Aout,
  output logic [31:0]  data_out
);
`ifdef STG3_DUAL_LANE_EN
  localparam int IW = 3;
`else
  localparam int IW = 4;
`endif
  typedef enum logic [1:0] {IDLE, ACC, OUT_REQ, OUT_REL} state_t;
  state_t state_q, state_d;
  logic rin_m_q, rin_s, aout_m_q, aout_s;
  logic ain_q, ain_d, rout_q, rout_d;
  logic [511:0] buf_q, buf_d;
  logic [31:0] acc_q, acc_d, dout_q, dout_d, sum;
  logic [IW-1:0] idx_q, idx_d;
  logic capture, done;

  assign capture  = state_q == IDLE && rin_s && !ain_q;
  assign done     = state_q == ACC && &idx_q;
  assign Ain      = ain_q;
  assign Rout     = rout_q;
  assign data_out = dout_q;

  always_comb begin
`ifdef STG3_DUAL_LANE_EN
    sum = acc_q + buf_q[{idx_q, 6'd0} +: 32] + buf_q[{idx_q, 6'd32} +: 32];
`else
    sum = acc_q + buf_q[{idx_q, 5'd0} +: 32];
`endif
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q == IDLE    ? (capture ? ACC : IDLE) :
              state_q == ACC     ? (done ? OUT_REQ : ACC) :
              state_q == OUT_REQ ? (aout_s ? OUT_REL : OUT_REQ) :
                                   (aout_s ? OUT_REL : IDLE);
  end

  // Ain drops on any edge that sees the request released, independent of state
  always_comb begin
    ain_d  = ain_q ? rin_s : capture;
    rout_d = done || (state_q == OUT_REQ && !aout_s);
    dout_d = done ? sum : dout_q;
    buf_d  = capture ? data_in : buf_q;
    acc_d  = capture ? '0 : state_q == ACC ? sum : acc_q;
    idx_d  = capture ? '0 : state_q == ACC ? idx_q + 1'b1 : idx_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rin_m_q  <= 1'b0;
      rin_s    <= 1'b0;
      aout_m_q <= 1'b0;
      aout_s   <= 1'b0;
      ain_q    <= 1'b0;
      rout_q   <= 1'b0;
      dout_q   <= '0;
      buf_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
    end else begin
      rin_m_q  <= Rin;
      rin_s    <= rin_m_q;
      aout_m_q <= Aout;
      aout_s   <= aout_m_q;
      ain_q    <= ain_d;
      rout_q   <= rout_d;
      dout_q   <= dout_d;
      buf_q    <= buf_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
    end
endmodule
